// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 31;
  localparam int unsigned CNT_W    = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } prio_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-requester round-robin grant with a registered tie-break pointer.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  prio_e r_state;
  prio_e w_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= PRI0;
    else        r_state <= w_next;
  end

  always_comb begin
    gnt    = '0;
    w_next = r_state;
    if (!hold) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (r_state == PRI0) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
      // The pointer moves away from whoever just won; no grant leaves it alone.
      if (gnt[0])      w_next = PRI1;
      else if (gnt[1]) w_next = PRI0;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between ALU writeback (0) and load return (1).
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG,
  parameter int unsigned CNT_W    = regfile_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ready0,
  input  logic              valid1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ready1,
  input  logic              wr_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              mux_sel,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [1:0]        w_gnt;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_conflict;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_mux_sel;
  logic [CNT_W-1:0]  r_conflict_cnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({valid1, valid0}),
    .hold  (wr_hold),
    .gnt   (w_gnt)
  );

  assign ready0     = w_gnt[0];
  assign ready1     = w_gnt[1];
  assign w_sel_addr = w_gnt[1] ? addr1 : addr0;
  assign w_sel_data = w_gnt[1] ? data1 : data0;
  assign w_conflict = valid0 & valid1 & ~wr_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_mux_sel <= 1'b0;
    end else if (|w_gnt) begin
      // Zero-register writes still complete the handshake but never reach the regfile.
      r_wr_en   <= (w_sel_addr != ADDR_W'(ZERO_REG));
      r_wr_addr <= w_sel_addr;
      r_wr_data <= w_sel_data;
      r_mux_sel <= w_gnt[1];
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   r_conflict_cnt <= '0;
    else if (w_conflict && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
  end

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign mux_sel      = r_mux_sel;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed checks of grant order, write latency, zero-reg, hold, reset and counter saturation.
module tb_regfile_wr_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid0, valid1, wr_hold;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          ready0, ready1;
  logic          wr_en, mux_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] conflict_cnt;

  int vectors = 0;
  int miscompares = 0;

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(31), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid0       (valid0),
    .addr0        (addr0),
    .data0        (data0),
    .ready0       (ready0),
    .valid1       (valid1),
    .addr1        (addr1),
    .data1        (data1),
    .ready1       (ready1),
    .wr_hold      (wr_hold),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .mux_sel      (mux_sel),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic sel);
    chk({tag, ".wr_en"},   wr_en,   en);
    chk({tag, ".wr_addr"}, wr_addr, a);
    chk({tag, ".wr_data"}, wr_data, d);
    chk({tag, ".mux_sel"}, mux_sel, sel);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, ".ready0"}, ready0, r0);
    chk({tag, ".ready1"}, ready1, r1);
  endtask

  initial begin
    reset = 1'b0; wr_hold = 1'b0;
    valid0 = 1'b0; addr0 = '0; data0 = '0;
    valid1 = 1'b0; addr1 = '0; data1 = '0;
    #12;
    chk_wr("reset", 1'b0, 5'd0, 64'd0, 1'b0);
    chk("reset.cnt", conflict_cnt, 0);
    reset = 1'b1;

    // idle
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle.ready0", ready0, 1'b0);
      chk("idle.ready1", ready1, 1'b0);
      chk("idle.wr_en", wr_en, 1'b0);
    end

    // single request from source 0
    valid0 = 1'b1; addr0 = 5'd5; data0 = 64'hDEAD_BEEF;
    chk_rdy("single", 1'b1, 1'b0);
    tick();
    valid0 = 1'b0;
    chk_wr("single", 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0);
    tick();
    chk_wr("single.after", 1'b0, 5'd5, 64'hDEAD_BEEF, 1'b0);

    // contention from a fresh reset, same destination
    reset = 1'b0; #2; reset = 1'b1;
    valid0 = 1'b1; addr0 = 5'd3; data0 = 64'h11;
    valid1 = 1'b1; addr1 = 5'd3; data1 = 64'h22;
    chk_rdy("cont.c0", 1'b1, 1'b0);
    tick();
    valid0 = 1'b0;
    chk_wr("cont.w0", 1'b1, 5'd3, 64'h11, 1'b0);
    chk("cont.cnt1", conflict_cnt, 1);
    chk_rdy("cont.c1", 1'b0, 1'b1);
    tick();
    valid1 = 1'b0;
    chk_wr("cont.w1", 1'b1, 5'd3, 64'h22, 1'b1);
    chk("cont.cnt1b", conflict_cnt, 1);

    // zero register: accepted, not written, pointer still toggles back to PRI0
    valid1 = 1'b1; addr1 = 5'd31; data1 = 64'hFF;
    chk_rdy("zero", 1'b0, 1'b1);
    tick();
    valid1 = 1'b0;
    chk_wr("zero", 1'b0, 5'd31, 64'hFF, 1'b1);
    valid0 = 1'b1; addr0 = 5'd7; data0 = 64'hA0;
    valid1 = 1'b1; addr1 = 5'd8; data1 = 64'hB0;
    chk_rdy("zero.next", 1'b1, 1'b0);
    tick();
    chk_wr("zero.next", 1'b1, 5'd7, 64'hA0, 1'b0);
    chk("zero.cnt", conflict_cnt, 2);

    // hold for three cycles with both requesters pending; pointer is PRI1
    wr_hold = 1'b1; addr0 = 5'd9; data0 = 64'hC0;
    chk_rdy("hold.c1", 1'b0, 1'b0);
    tick();
    chk("hold.c2.wr_en", wr_en, 1'b0);
    chk("hold.c2.data", wr_data, 64'hA0);
    chk_rdy("hold.c2", 1'b0, 1'b0);
    tick();
    chk("hold.c3.wr_en", wr_en, 1'b0);
    chk_rdy("hold.c3", 1'b0, 1'b0);
    tick();
    chk("hold.end.wr_en", wr_en, 1'b0);
    chk("hold.end.cnt", conflict_cnt, 2);
    wr_hold = 1'b0;
    chk_rdy("hold.rel", 1'b0, 1'b1);
    tick();
    valid1 = 1'b0;
    chk_wr("hold.w1", 1'b1, 5'd8, 64'hB0, 1'b1);
    chk("hold.cnt3", conflict_cnt, 3);
    chk_rdy("hold.r0", 1'b1, 1'b0);
    tick();
    valid0 = 1'b0;
    chk_wr("hold.w0", 1'b1, 5'd9, 64'hC0, 1'b0);

    // asynchronous reset right after a transfer; pointer was PRI1 before it
    reset = 1'b0;
    #1;
    chk_wr("areset", 1'b0, 5'd0, 64'd0, 1'b0);
    chk("areset.cnt", conflict_cnt, 0);
    reset = 1'b1;
    valid0 = 1'b1; addr0 = 5'd1; data0 = 64'h1;
    valid1 = 1'b1; addr1 = 5'd2; data1 = 64'h2;
    chk_rdy("areset.grant", 1'b1, 1'b0);
    tick();
    valid0 = 1'b0;
    chk_wr("areset.w0", 1'b1, 5'd1, 64'h1, 1'b0);

    // back-to-back on source 1 alone
    for (int i = 0; i < 3; i++) begin
      data1 = 64'h100 + 64'(i);
      chk_rdy("b2b", 1'b0, 1'b1);
      tick();
      chk_wr("b2b", 1'b1, 5'd2, 64'h100 + 64'(i), 1'b1);
    end
    valid1 = 1'b0;

    // counter saturation at 2^CW-1 with alternating grants
    reset = 1'b0; #2; reset = 1'b1;
    valid0 = 1'b1; valid1 = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat.14", conflict_cnt, 14);
    tick();
    chk("sat.15", conflict_cnt, 15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat.hold", conflict_cnt, 15);
    valid0 = 1'b0; valid1 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
